// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: buffers per-lane resolved-branch updates and issues one per cycle to the predictor,
// letting the lowest-index mispredict bypass the queue so BHR repair is immediate.
module bp_update_scheduler #(
    parameter int N     = 2,
    parameter int DEPTH = 8,
    parameter int PW    = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N-1:0]           in_valid,
    input  logic [N-1:0][PW-1:0]   in_packets,
    input  logic [N-1:0]           in_taken,
    input  logic [N-1:0]           in_mispred,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [PW-1:0]          out_packet,
    output logic                   out_taken,
    output logic                   out_mispred,
    output logic [CNT_W-1:0]       count,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = N > 1 ? $clog2(N) : 1;

    logic [PW+1:0]    mem [DEPTH];
    logic [AW-1:0]    head, tail;
    logic [N-1:0]     acc, enq;
    logic [AW-1:0]    slot [N];
    logic [CNT_W-1:0] n_enq;
    logic [IW-1:0]    sel;
    logic             byp_m, byp_e, use_byp, use_head;

    assign in_ready = 32'(count) + N <= DEPTH;
    assign empty    = count == '0 && !out_valid;

    always_comb begin
        acc   = in_ready ? in_valid : '0;
        byp_m = 1'b0;
        byp_e = 1'b0;
        sel   = '0;
        // Descending scans leave the lowest matching lane in sel.
        for (int i = N - 1; i >= 0; i--)
            if (acc[i] && in_mispred[i]) begin
                byp_m = 1'b1;
                sel   = IW'(i);
            end
        if (!byp_m)
            for (int i = N - 1; i >= 0; i--)
                if (acc[i]) begin
                    byp_e = 1'b1;
                    sel   = IW'(i);
                end
        use_head = !byp_m && count != '0;
        use_byp  = byp_m || (byp_e && count == '0);
        enq      = acc;
        if (use_byp) enq[sel] = 1'b0;
        n_enq = '0;
        for (int i = 0; i < N; i++) begin
            slot[i] = tail + AW'(n_enq);
            n_enq   = n_enq + CNT_W'(enq[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_packet  <= '0;
            out_taken   <= 1'b0;
            out_mispred <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if (enq[i]) mem[slot[i]] <= {in_packets[i], in_taken[i], in_mispred[i]};
            tail      <= tail + AW'(n_enq);
            head      <= head + AW'(use_head);
            count     <= count + n_enq - CNT_W'(use_head);
            out_valid <= use_byp || use_head;
            {out_packet, out_taken, out_mispred} <= use_byp  ? {in_packets[sel], in_taken[sel], in_mispred[sel]} :
                                                    use_head ? mem[head] : '0;
        end
    end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb_bp_update_scheduler: directed vector table, fill/stall, random and reset sequences,
// all checked against a queue-based reference model of the scheduling rules.
module tb_bp_update_scheduler;
    localparam int N = 2, DEPTH = 8, PW = 16, CNT_W = 4;

    logic clock = 1'b0, reset = 1'b1;
    logic [N-1:0] in_valid = '0, in_taken = '0, in_mispred = '0;
    logic [N-1:0][PW-1:0] in_packets = '0;
    logic in_ready, out_valid, out_taken, out_mispred, empty;
    logic [PW-1:0] out_packet;
    logic [CNT_W-1:0] count;

    bp_update_scheduler #(.N(N), .DEPTH(DEPTH), .PW(PW), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_packets(in_packets),
        .in_taken(in_taken), .in_mispred(in_mispred), .in_ready(in_ready),
        .out_valid(out_valid), .out_packet(out_packet), .out_taken(out_taken),
        .out_mispred(out_mispred), .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    typedef struct packed {logic [PW-1:0] p; logic t; logic m;} ent_t;
    typedef struct {
        logic [1:0] v, m, t; logic [PW-1:0] p0, p1;
        logic ov; logic [PW-1:0] op; logic ot, om; int cnt;
    } vec_t;

    ent_t q[$];
    ent_t exp_o;
    logic exp_v, last_rdy;
    int n_chk = 0, n_fail = 0;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: the update queue is a plain list; one cycle of scheduling per call.
    task automatic step(input logic [N-1:0] v, m, t, input logic [N-1:0][PW-1:0] p);
        int b;
        @(negedge clock);
        reset = 1'b0; in_valid = v; in_mispred = m; in_taken = t; in_packets = p;
        last_rdy = (DEPTH - q.size()) >= N;
        #1 chk("in_ready", in_ready, last_rdy);
        b = -1;
        exp_v = 1'b1;
        exp_o = '0;
        if (last_rdy)
            for (int i = 0; i < N; i++) if (b < 0 && v[i] && m[i]) b = i;
        if (b >= 0) exp_o = '{p[b], t[b], m[b]};
        else if (q.size() > 0) exp_o = q.pop_front();
        else if (last_rdy && v != '0) begin
            for (int i = 0; i < N; i++) if (b < 0 && v[i]) b = i;
            exp_o = '{p[b], t[b], m[b]};
        end else exp_v = 1'b0;
        if (last_rdy)
            for (int i = 0; i < N; i++) if (v[i] && i != b) q.push_back('{p[i], t[i], m[i]});
        @(posedge clock);
        #1;
        chk("out_valid", out_valid, exp_v);
        if (exp_v) begin
            chk("out_packet", out_packet, exp_o.p);
            chk("out_taken", out_taken, exp_o.t);
            chk("out_mispred", out_mispred, exp_o.m);
        end
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0 && !exp_v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0);
    endtask

    initial begin
        logic [PW-1:0] seq;
        logic saw_stall;
        int guard;
        tbl[0]  = '{2'b11, 2'b00, 2'b01, 16'hA001, 16'hA002, 1'b1, 16'hA001, 1'b1, 1'b0, 1};
        tbl[1]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'hA002, 1'b0, 1'b0, 0};
        tbl[2]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0};
        tbl[3]  = '{2'b11, 2'b00, 2'b00, 16'hB001, 16'hB002, 1'b1, 16'hB001, 1'b0, 1'b0, 1};
        tbl[4]  = '{2'b11, 2'b00, 2'b11, 16'hB003, 16'hB004, 1'b1, 16'hB002, 1'b0, 1'b0, 2};
        tbl[5]  = '{2'b11, 2'b00, 2'b00, 16'hB005, 16'hB006, 1'b1, 16'hB003, 1'b1, 1'b0, 3};
        tbl[6]  = '{2'b10, 2'b10, 2'b00, 16'h0000, 16'hC001, 1'b1, 16'hC001, 1'b0, 1'b1, 3};
        tbl[7]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'hB004, 1'b1, 1'b0, 2};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'hB005, 1'b0, 1'b0, 1};
        tbl[9]  = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'hB006, 1'b0, 1'b0, 0};
        tbl[10] = '{2'b11, 2'b11, 2'b10, 16'hD001, 16'hD002, 1'b1, 16'hD001, 1'b0, 1'b1, 1};
        tbl[11] = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'hD002, 1'b1, 1'b1, 0};
        tbl[12] = '{2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_packet", out_packet, 0);

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].m, tbl[k].t, {tbl[k].p1, tbl[k].p0});
            chk("tbl_valid", out_valid, tbl[k].ov);
            if (tbl[k].ov) begin
                chk("tbl_packet", out_packet, tbl[k].op);
                chk("tbl_taken", out_taken, tbl[k].ot);
                chk("tbl_mispred", out_mispred, tbl[k].om);
            end
            chk("tbl_count", count, tbl[k].cnt);
        end

        // Fill until in_ready drops, holding the same pair while stalled.
        seq = 16'h1000;
        saw_stall = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(2'b11, 2'b00, 2'(c), {seq + 16'd1, seq});
            if (last_rdy) seq = seq + 16'd2;
            else saw_stall = 1'b1;
        end
        chk("fill_stall_seen", saw_stall, 1);
        idle(DEPTH + 2);

        // Random phases alternately fill and drain to sweep the pointers round the ring.
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v, m;
            int pv;
            pv = ((c / 12) % 2 == 0) ? 85 : 20;
            for (int i = 0; i < N; i++) begin
                v[i] = $urandom_range(99) < pv;
                m[i] = $urandom_range(99) < 12;
            end
            step(v, m, 2'($urandom), {16'($urandom), 16'($urandom)});
        end
        idle(DEPTH + 2);

        // Build five queued entries with a valid output, then reset mid-flight.
        guard = 0;
        while (q.size() < 5 && guard < 20) begin
            step(2'b11, 2'b00, 2'b01, {16'($urandom), 16'($urandom)});
            guard++;
        end
        chk("pre_rst_count", count, 5);
        chk("pre_rst_valid", out_valid, 1);
        @(negedge clock);
        reset = 1'b1; in_valid = 2'b11; in_mispred = 2'b01;
        @(posedge clock);
        #1;
        q.delete();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_empty", empty, 1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
